mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port to one-port memory arbiter between the pipeline's instruction-fetch path and data load/store path, both of which issue through the datapath-cache interface. It sits between the datapath-side request ports and the single-ported RAM. It serialises requests with a registered grant FSM. Data accesses win contention, and a bounded-streak rule prevents fetch starvation. Each requester sees a wait signal until its access completes.

## Interface
- MAX_DSTREAK, default 4: consecutive contested data grants allowed before fetch is forced to win; legal range 1..15.
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request; held until iwait low.
- iaddr  in  32  instruction address.
- iload  out  32  instruction read data; valid when iwait low.
- iwait  out  1  instruction access not yet complete.
- dREN  in  1  data read request.
- dWEN  in  1  data write request; if both dREN and dWEN are high, the access is a write.
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dload  out  32  data read data; valid when dwait low and dREN high.
- dwait  out  1  data access not yet complete.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramready  in  1  RAM completes the current access this cycle.

## Operation
- The FSM has three states: IDLE, IBUSY and DBUSY. Reset state is IDLE, and dstreak resets to 0.
- In IDLE:
  - If dREN or dWEN is high, the next state is DBUSY. The exception: if iREN is also high and dstreak == MAX_DSTREAK, the next state is IBUSY.
  - Otherwise, if iREN is high, the next state is IBUSY.
  - Otherwise, the FSM stays in IDLE.
- dstreak update happens only on IDLE→DBUSY and IDLE→IBUSY transitions:
  - On a DBUSY grant with iREN high, dstreak increments, saturating at MAX_DSTREAK.
  - On a DBUSY grant with iREN low, dstreak clears to 0.
  - Any IBUSY grant clears dstreak to 0.
- In IBUSY:
  - ramREN=1, ramWEN=0, ramaddr=iaddr (live).
  - When ramready=1, the next state is IDLE.
  - If iREN drops before ramready, the access aborts and the next state is IDLE.
- In DBUSY:
  - ramWEN=dWEN, ramREN=dREN&&!dWEN, ramaddr=daddr, ramstore=dstore.
  - When ramready=1, the next state is IDLE.
  - If dREN and dWEN both drop, the access aborts and the next state is IDLE.
- Output functions:
  - iwait = iREN && !(state==IBUSY && ramready).
  - dwait = (dREN||dWEN) && !(state==DBUSY && ramready).
  - iload = ramload and dload = ramload. Both are pass-throughs and are only meaningful while the corresponding wait is low.
- In IDLE, all RAM strobes are 0, and ramaddr and ramstore are 0.
- A ramready that arrives in IDLE is ignored.
- Requesters must not change the request type mid-access. Address and data changes mid-access are passed straight through to the RAM.

## Timing
- Reset values:
  - State is IDLE and dstreak is 0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - iwait and dwait follow their formulas. With no requests both are 0; with a request asserted during reset the corresponding wait is 1.
- Minimum access latency is 2 cycles from request assertion:
  - Cycle 0 is IDLE, when the request is sampled.
  - Cycle 1 is BUSY; if ramready=1 here, the wait signal is low in this cycle.
- Each additional cycle of ramready=0 adds one cycle.
- After completion the FSM spends at least one cycle in IDLE. The requester deasserts or renews its request on the cycle after its wait goes low, so back-to-back accesses from one requester take 2 cycles each.
- Simultaneous new requests in IDLE are resolved in the same cycle by the priority and streak rule. The loser's wait stays high throughout.
- Asynchronous reset mid-access forces IDLE immediately and drops RAM strobes combinationally. The interrupted access is lost, and the requester must reissue it.
- After an abort, the RAM strobes are low in the first IDLE cycle.

## Test plan
- Single fetch: iREN=1, iaddr=0x40, and ramready=1 on the first IBUSY cycle. Required: ramREN=1 and ramaddr=0x40 in cycle 1; iwait goes low in cycle 1 with iload=ramload=0x8C010004; state returns to IDLE in cycle 2.
- Contention: iREN and dREN both asserted in IDLE, daddr=0x100, ramready=1 every BUSY cycle. Required: DBUSY is granted first and dwait goes low in cycle 1; IBUSY is granted after the requester drops dREN; iwait stays 1 until its own BUSY+ready cycle.
- Starvation bound: MAX_DSTREAK=4, with iREN held and dREN re-requested every access. Required: exactly 4 DBUSY grants, then an IBUSY grant, with dstreak back to 0.
- Write precedence and wait states: dREN=dWEN=1, daddr=0x200, dstore=0xDEADBEEF, ramready low for 3 cycles. Required: ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait=1 for 4 cycles and low on the 5th, which is when ramready=1.
- Abort: an instruction access is in IBUSY and iREN drops while ramready=0. Required: the next cycle is IDLE and ramREN=0. A later ramready=1 has no effect and neither wait signal toggles.
- Reset mid-access: nRST asserted while in DBUSY with ramWEN=1. Required: ramWEN=0 with no clock edge needed. After nRST releases with dWEN still high, an access is re-granted to DBUSY within 1 cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data load/store requests onto a single-ported RAM.
// Data wins contention; a bounded streak counter stops fetch from starving.
module mem_arbiter #(
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ramready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    localparam logic [3:0] MaxStreak = 4'(MAX_DSTREAK);

    state_t     state_q, state_d;
    logic [3:0] dstreak_q, dstreak_d;
    logic       dReq;

    assign dReq = dREN || dWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= IDLE;
            dstreak_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            dstreak_q <= dstreak_d;
        end
    end

    // The streak only moves on grants out of IDLE; a full streak hands the next contested slot to fetch.
    always_comb begin
        state_d   = state_q;
        dstreak_d = dstreak_q;
        unique case (state_q)
            IDLE: begin
                if (dReq && !(iREN && (dstreak_q == MaxStreak))) begin
                    state_d = DBUSY;
                    if (!iREN) begin
                        dstreak_d = 4'd0;
                    end else if (dstreak_q != MaxStreak) begin
                        dstreak_d = dstreak_q + 4'd1;
                    end
                end else if (iREN) begin
                    state_d   = IBUSY;
                    dstreak_d = 4'd0;
                end
            end
            IBUSY: begin
                if (ramready || !iREN) begin
                    state_d = IDLE;
                end
            end
            DBUSY: begin
                if (ramready || !dReq) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = 32'd0;
        ramstore = 32'd0;
        unique case (state_q)
            IBUSY: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
            end
            DBUSY: begin
                ramWEN   = dWEN;
                ramREN   = dREN && !dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
            end
            default: begin
            end
        endcase
    end

    assign iwait = iREN && !((state_q == IBUSY) && ramready);
    assign dwait = dReq && !((state_q == DBUSY) && ramready);
    assign iload = ramload;
    assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected completions into a queue,
// and a negedge monitor pops and compares each completed access.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, ramready;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        iwait, dwait, ramREN, ramWEN;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic        isData;
        logic [31:0] addr;
        logic        ren;
        logic        wen;
        logic [31:0] store;
        logic [31:0] load;
    } exp_t;

    exp_t expQ[$];

    mem_arbiter #(.MAX_DSTREAK(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramready(ramready)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus();
        @(posedge CLK);
        #1;
    endtask

    task automatic pushExp(input logic isData, input logic [31:0] addr, input logic ren,
                           input logic wen, input logic [31:0] store, input logic [31:0] load);
        exp_t e;
        e.isData = isData; e.addr = addr; e.ren = ren; e.wen = wen;
        e.store = store; e.load = load;
        expQ.push_back(e);
    endtask

    task automatic scoreCompletion(input logic isData, input logic [31:0] load);
        exp_t e;
        if (expQ.size() == 0) begin
            checkOutput("sbUnexpectedCompletion", 32'd1, 32'd0);
        end else begin
            e = expQ.pop_front();
            checkOutput("sbPort", {31'd0, isData}, {31'd0, e.isData});
            checkOutput("sbAddr", ramaddr, e.addr);
            checkOutput("sbRamREN", {31'd0, ramREN}, {31'd0, e.ren});
            checkOutput("sbRamWEN", {31'd0, ramWEN}, {31'd0, e.wen});
            if (e.wen) checkOutput("sbStore", ramstore, e.store);
            else       checkOutput("sbLoad", load, e.load);
        end
    endtask

    // Monitor: an access completes when a requester's wait is low while it is requesting.
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            if (iREN && !iwait) scoreCompletion(1'b0, iload);
            if ((dREN || dWEN) && !dwait) scoreCompletion(1'b1, dload);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0;

        // Reset values
        #2;
        checkOutput("rstRamREN", {31'd0, ramREN}, 32'd0);
        checkOutput("rstRamWEN", {31'd0, ramWEN}, 32'd0);
        checkOutput("rstRamAddr", ramaddr, 32'd0);
        checkOutput("rstRamStore", ramstore, 32'd0);
        checkOutput("rstIwait", {31'd0, iwait}, 32'd0);
        checkOutput("rstDwait", {31'd0, dwait}, 32'd0);
        iREN = 1'b1;
        #1;
        checkOutput("rstIwaitReq", {31'd0, iwait}, 32'd1);
        iREN = 1'b0;
        applyStimulus();
        nRST = 1'b1;

        // Single fetch
        iREN = 1'b1; iaddr = 32'h40; ramload = 32'h8C010004;
        pushExp(1'b0, 32'h40, 1'b1, 1'b0, 32'h0, 32'h8C010004);
        @(negedge CLK);
        checkOutput("fetchC0Iwait", {31'd0, iwait}, 32'd1);
        checkOutput("fetchC0RamREN", {31'd0, ramREN}, 32'd0);
        applyStimulus();
        ramready = 1'b1;
        @(negedge CLK);
        checkOutput("fetchC1RamREN", {31'd0, ramREN}, 32'd1);
        checkOutput("fetchC1Addr", ramaddr, 32'h40);
        checkOutput("fetchC1Iwait", {31'd0, iwait}, 32'd0);
        checkOutput("fetchC1Iload", iload, 32'h8C010004);
        applyStimulus();
        iREN = 1'b0; ramready = 1'b0;
        @(negedge CLK);
        checkOutput("fetchC2RamREN", {31'd0, ramREN}, 32'd0);
        checkOutput("fetchC2Addr", ramaddr, 32'h0);

        // Contention: data first, fetch after dREN drops
        applyStimulus();
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100; dstore = 32'h0;
        ramready = 1'b1; ramload = 32'h11112222;
        pushExp(1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 32'h11112222);
        pushExp(1'b0, 32'h44, 1'b1, 1'b0, 32'h0, 32'h11112222);
        @(negedge CLK);
        checkOutput("contC0Iwait", {31'd0, iwait}, 32'd1);
        checkOutput("contC0Dwait", {31'd0, dwait}, 32'd1);
        applyStimulus();
        @(negedge CLK);
        checkOutput("contC1Dwait", {31'd0, dwait}, 32'd0);
        checkOutput("contC1Iwait", {31'd0, iwait}, 32'd1);
        applyStimulus();
        dREN = 1'b0;
        @(negedge CLK);
        checkOutput("contC2Iwait", {31'd0, iwait}, 32'd1);
        checkOutput("contC2RamREN", {31'd0, ramREN}, 32'd0);
        applyStimulus();
        @(negedge CLK);
        checkOutput("contC3Iwait", {31'd0, iwait}, 32'd0);
        applyStimulus();
        iREN = 1'b0;

        // Starvation bound: two rounds of 4 data grants then 1 fetch grant
        iREN = 1'b1; iaddr = 32'h80; dREN = 1'b1; daddr = 32'h300;
        ramready = 1'b1; ramload = 32'h5A5A5A5A;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) pushExp(1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 32'h5A5A5A5A);
            pushExp(1'b0, 32'h80, 1'b1, 1'b0, 32'h0, 32'h5A5A5A5A);
        end
        repeat (20) applyStimulus();
        iREN = 1'b0; dREN = 1'b0; ramready = 1'b0;
        @(negedge CLK);
        checkOutput("starveIdleRamREN", {31'd0, ramREN}, 32'd0);
        checkOutput("starveAllGranted", expQ.size(), 32'd0);

        // Write precedence with three wait states
        applyStimulus();
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF; ramload = 32'h0;
        pushExp(1'b1, 32'h200, 1'b0, 1'b1, 32'hDEADBEEF, 32'h0);
        @(negedge CLK);
        checkOutput("wrC0Dwait", {31'd0, dwait}, 32'd1);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus();
            @(negedge CLK);
            checkOutput("wrWaitDwait", {31'd0, dwait}, 32'd1);
            checkOutput("wrWaitRamWEN", {31'd0, ramWEN}, 32'd1);
            checkOutput("wrWaitRamREN", {31'd0, ramREN}, 32'd0);
            checkOutput("wrWaitStore", ramstore, 32'hDEADBEEF);
        end
        applyStimulus();
        ramready = 1'b1;
        @(negedge CLK);
        checkOutput("wrC4Dwait", {31'd0, dwait}, 32'd0);
        applyStimulus();
        dREN = 1'b0; dWEN = 1'b0; ramready = 1'b0;

        // Abort of an instruction access
        iREN = 1'b1; iaddr = 32'h500;
        applyStimulus();
        @(negedge CLK);
        checkOutput("abortBusyRamREN", {31'd0, ramREN}, 32'd1);
        #2;
        iREN = 1'b0;
        applyStimulus();
        ramready = 1'b1;
        @(negedge CLK);
        checkOutput("abortIdleRamREN", {31'd0, ramREN}, 32'd0);
        checkOutput("abortIwait", {31'd0, iwait}, 32'd0);
        checkOutput("abortDwait", {31'd0, dwait}, 32'd0);
        applyStimulus();
        @(negedge CLK);
        checkOutput("abortLateReadyRamREN", {31'd0, ramREN}, 32'd0);
        checkOutput("abortLateReadyIwait", {31'd0, iwait}, 32'd0);
        applyStimulus();
        ramready = 1'b0;

        // Asynchronous reset during a data write
        dWEN = 1'b1; daddr = 32'h600; dstore = 32'h12345678;
        applyStimulus();
        @(negedge CLK);
        checkOutput("rstMidRamWEN", {31'd0, ramWEN}, 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        checkOutput("rstAsyncRamWEN", {31'd0, ramWEN}, 32'd0);
        checkOutput("rstAsyncDwait", {31'd0, dwait}, 32'd1);
        applyStimulus();
        nRST = 1'b1; ramready = 1'b1;
        pushExp(1'b1, 32'h600, 1'b0, 1'b1, 32'h12345678, 32'h0);
        @(negedge CLK);
        checkOutput("rstRelIdleRamWEN", {31'd0, ramWEN}, 32'd0);
        applyStimulus();
        @(negedge CLK);
        checkOutput("rstRegrantRamWEN", {31'd0, ramWEN}, 32'd1);
        checkOutput("rstRegrantDwait", {31'd0, dwait}, 32'd0);
        applyStimulus();
        dWEN = 1'b0; ramready = 1'b0;

        repeat (2) applyStimulus();
        checkOutput("sbDrained", expQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
